// File: rtl/ddr_rx_checker.sv
// DDR receive checker: captures a pin on both clock edges, realigns each pair to the rising edge
// and checks it against a forwarded-clock or PRBS7 pattern with lock tracking and statistics.
module ddr_rx_checker #(
    parameter int unsigned PATTERN  = 0,
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned LOSS_CNT = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             ddr_in,
    input  logic             clear_counts,
    output logic             locked,
    output logic [1:0]       state,
    output logic             rx_rise,
    output logic             rx_fall,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] cycles_checked,
    output logic             err_sticky
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned BW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHunt   = 2'd1,
        StLocked = 2'd2
    } state_e;

    state_e           state_q;
    logic             rise_q, fall_q;
    logic             rx_rise_q, rx_fall_q;
    logic [6:0]       hist_q;
    logic [GW-1:0]    good_run_q;
    logic [BW-1:0]    bad_run_q;
    logic [CNT_W-1:0] err_count_q, cycles_checked_q;
    logic             err_sticky_q;
    logic             exp_rise, exp_fall, err;
    logic             chk_inc, err_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rise_q <= 1'b0;
        else        rise_q <= ddr_in;
    end

    // Fall bit is taken on the negedge following the rise sample.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) fall_q <= 1'b0;
        else        fall_q <= ddr_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_rise_q <= 1'b0;
            rx_fall_q <= 1'b0;
        end else begin
            rx_rise_q <= rise_q;
            rx_fall_q <= fall_q;
        end
    end

    // PRBS7 predictions come from the pre-shift history, so the checker self-synchronises.
    always_comb begin
        if (PATTERN == 0) begin
            exp_rise = 1'b1;
            exp_fall = 1'b0;
        end else begin
            exp_rise = hist_q[6] ^ hist_q[5];
            exp_fall = hist_q[5] ^ hist_q[4];
        end
        err     = (rx_rise_q != exp_rise) || (rx_fall_q != exp_fall);
        chk_inc = enable && (state_q == StLocked);
        err_inc = chk_inc && err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            hist_q           <= '0;
            good_run_q       <= '0;
            bad_run_q        <= '0;
            err_count_q      <= '0;
            cycles_checked_q <= '0;
            err_sticky_q     <= 1'b0;
        end else begin
            if (state_q != StIdle) hist_q <= {hist_q[4:0], rx_rise_q, rx_fall_q};

            if (!enable) begin
                state_q    <= StIdle;
                good_run_q <= '0;
                bad_run_q  <= '0;
            end else begin
                case (state_q)
                    StIdle: state_q <= StHunt;
                    StHunt: begin
                        if (err) begin
                            good_run_q <= '0;
                        end else if (good_run_q == GW'(LOCK_CNT - 1)) begin
                            state_q    <= StLocked;
                            good_run_q <= '0;
                            bad_run_q  <= '0;
                        end else begin
                            good_run_q <= good_run_q + GW'(1);
                        end
                    end
                    StLocked: begin
                        if (!err) begin
                            bad_run_q <= '0;
                        end else if (bad_run_q == BW'(LOSS_CNT - 1)) begin
                            state_q    <= StHunt;
                            bad_run_q  <= '0;
                            good_run_q <= '0;
                        end else begin
                            bad_run_q <= bad_run_q + BW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end

            // A clear drops any increment landing in the same cycle.
            if (clear_counts) begin
                err_count_q      <= '0;
                cycles_checked_q <= '0;
                err_sticky_q     <= 1'b0;
            end else begin
                if (chk_inc && !(&cycles_checked_q)) cycles_checked_q <= cycles_checked_q + CNT_W'(1);
                if (err_inc) begin
                    err_sticky_q <= 1'b1;
                    if (!(&err_count_q)) err_count_q <= err_count_q + CNT_W'(1);
                end
            end
        end
    end

    assign state          = state_q;
    assign locked         = (state_q == StLocked);
    assign rx_rise        = rx_rise_q;
    assign rx_fall        = rx_fall_q;
    assign err_count      = err_count_q;
    assign cycles_checked = cycles_checked_q;
    assign err_sticky     = err_sticky_q;

endmodule

// File: tb/tb_ddr_rx_checker.sv
// Scoreboard bench for ddr_rx_checker: forwarded-clock, PRBS7 and narrow-counter instances.
module tb_ddr_rx_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic en0 = 0, en1 = 0, en2 = 0;
    logic clr0 = 0, clr1 = 0, clr2 = 0;
    logic ddr0 = 0, ddr1 = 0, ddr2 = 0;
    logic pr0 = 1, pf0 = 0, pr1 = 0, pf1 = 0, pr2 = 1, pf2 = 0;
    logic fl0, fl1, fl2;

    logic lk0, lk1, lk2, rr0, rr1, rr2, rf0, rf1, rf2, sk0, sk1, sk2;
    logic [1:0] st0, st1, st2;
    logic [31:0] ec0, ec1, cc0, cc1;
    logic [2:0] ec2, cc2;

    ddr_rx_checker #(.PATTERN(0), .LOCK_CNT(16), .LOSS_CNT(4), .CNT_W(32)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(en0), .ddr_in(ddr0), .clear_counts(clr0),
        .locked(lk0), .state(st0), .rx_rise(rr0), .rx_fall(rf0), .err_count(ec0),
        .cycles_checked(cc0), .err_sticky(sk0));

    ddr_rx_checker #(.PATTERN(1), .LOCK_CNT(16), .LOSS_CNT(4), .CNT_W(32)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .ddr_in(ddr1), .clear_counts(clr1),
        .locked(lk1), .state(st1), .rx_rise(rr1), .rx_fall(rf1), .err_count(ec1),
        .cycles_checked(cc1), .err_sticky(sk1));

    ddr_rx_checker #(.PATTERN(0), .LOCK_CNT(16), .LOSS_CNT(4), .CNT_W(3)) u2 (
        .clk(clk), .rst_n(rst_n), .enable(en2), .ddr_in(ddr2), .clear_counts(clr2),
        .locked(lk2), .state(st2), .rx_rise(rr2), .rx_fall(rf2), .err_count(ec2),
        .cycles_checked(cc2), .err_sticky(sk2));

    // Pair (pr, pf) set during cycle N is on the pin around posedge N+1 and the negedge after it.
    always begin
        @(negedge clk);
        #2;
        fl0 = pf0; fl1 = pf1; fl2 = pf2;
        ddr0 = pr0; ddr1 = pr1; ddr2 = pr2;
        @(posedge clk);
        #2;
        ddr0 = fl0; ddr1 = fl1; ddr2 = fl2;
    end

    // PRBS7 source, x^7+x^6+1, seeded 7'h7F; rise bit is the older bit unless swapped.
    logic [6:0] lfsr = 7'h7F;
    logic swap1 = 1'b1;
    logic gb0, gb1;
    always @(posedge clk) begin
        #1;
        gb0  = lfsr[6] ^ lfsr[5];
        lfsr = {lfsr[5:0], gb0};
        gb1  = lfsr[6] ^ lfsr[5];
        lfsr = {lfsr[5:0], gb1};
        if (swap1) begin pr1 = gb1; pf1 = gb0; end
        else       begin pr1 = gb0; pf1 = gb1; end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        int          dut;
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;
    chk_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int dly, input int dut, input int sel, input logic [31:0] exp,
                             input string name);
        sb.push_back('{at: cyc + dly, dut: dut, sel: sel, exp: exp, name: name});
    endtask

    // sel: 0 state, 1 locked, 2 err_count, 3 cycles_checked, 4 err_sticky, 5 OR of all outputs
    function automatic logic [31:0] peek(input int dut, input int sel);
        logic [31:0] v;
        v = '0;
        case (dut)
            0: case (sel)
                0: v = {30'd0, st0};
                1: v = {31'd0, lk0};
                2: v = ec0;
                3: v = cc0;
                4: v = {31'd0, sk0};
                default: v = {31'd0, lk0 | (|st0) | rr0 | rf0 | (|ec0) | (|cc0) | sk0};
            endcase
            1: case (sel)
                0: v = {30'd0, st1};
                1: v = {31'd0, lk1};
                2: v = ec1;
                3: v = cc1;
                4: v = {31'd0, sk1};
                default: v = {31'd0, lk1 | (|st1) | rr1 | rf1 | (|ec1) | (|cc1) | sk1};
            endcase
            default: case (sel)
                0: v = {30'd0, st2};
                1: v = {31'd0, lk2};
                2: v = {29'd0, ec2};
                3: v = {29'd0, cc2};
                4: v = {31'd0, sk2};
                default: v = {31'd0, lk2 | (|st2) | rr2 | rf2 | (|ec2) | (|cc2) | sk2};
            endcase
        endcase
        return v;
    endfunction

    // Monitor: on each negedge, retire every expectation scheduled for this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                logic [31:0] act;
                act = peek(sb[i].dut, sb[i].sel);
                checks++;
                if (act !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s dut%0d cycle %0d got %0h expected %0h", sb[i].name,
                             sb[i].dut, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    // Forwarded-clock instance: lock, single error, loss/relock, clear, disable.
    task automatic proc_a();
        en0 = 1'b1;                                    // cycle 5
        expect_at(1, 0, 0, 1, "hunt_entry");
        expect_at(16, 0, 0, 1, "hunt_before_lock");
        expect_at(17, 0, 0, 2, "lock_state");
        expect_at(17, 0, 1, 1, "lock_flag");
        expect_at(17, 0, 3, 0, "chk_at_lock");
        expect_at(18, 0, 3, 1, "chk_first");
        expect_at(22, 0, 3, 5, "chk_rate");
        expect_at(22, 0, 2, 0, "no_err_clean");
        tick(25);                                      // cycle 30
        pf0 = 1'b1;
        expect_at(2, 0, 2, 0, "err_latency");
        expect_at(3, 0, 2, 1, "single_err");
        expect_at(3, 0, 4, 1, "sticky_set");
        expect_at(3, 0, 1, 1, "lock_kept");
        expect_at(3, 0, 0, 2, "state_kept");
        tick(1);
        pf0 = 1'b0;
        tick(4);                                       // cycle 35
        pr0 = 1'b0;
        expect_at(5, 0, 2, 4, "loss_err3");
        expect_at(5, 0, 0, 2, "loss_still_locked");
        expect_at(6, 0, 2, 5, "loss_err4");
        expect_at(6, 0, 0, 1, "loss_to_hunt");
        expect_at(6, 0, 1, 0, "loss_unlocked");
        expect_at(21, 0, 0, 1, "relock_not_early");
        expect_at(22, 0, 0, 2, "relock_exact");
        expect_at(22, 0, 2, 5, "relock_err_held");
        tick(4);
        pr0 = 1'b1;
        tick(26);                                      // cycle 65
        pf0 = 1'b1;
        expect_at(2, 0, 2, 5, "pre_clear_cnt");
        expect_at(3, 0, 2, 0, "clear_err");
        expect_at(3, 0, 4, 0, "clear_sticky");
        expect_at(3, 0, 3, 0, "clear_chk");
        expect_at(3, 0, 1, 1, "clear_lock_kept");
        expect_at(4, 0, 3, 1, "chk_after_clear");
        tick(1);
        pf0 = 1'b0;
        tick(1);
        clr0 = 1'b1;
        tick(1);
        clr0 = 1'b0;
        tick(7);                                       // cycle 75
        en0 = 1'b0;
        expect_at(1, 0, 0, 0, "disable_idle");
        expect_at(1, 0, 1, 0, "disable_unlock");
        expect_at(1, 0, 3, 7, "disable_chk_held");
        expect_at(1, 0, 2, 0, "disable_err_held");
        expect_at(4, 0, 3, 7, "idle_chk_held");
        tick(5);
    endtask

    // PRBS7 instance: swapped order never locks, true order locks and stays clean.
    task automatic proc_b();
        bit got;
        en1 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            expect_at(0, 1, 1, 0, "swap_no_lock");
            tick(1);
        end
        swap1 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick(1);
            if (lk1) got = 1'b1;
        end
        expect_at(0, 1, 1, 1, "prbs_lock");
        tick(1000);
        expect_at(0, 1, 2, 0, "prbs_err_zero");
        expect_at(0, 1, 1, 1, "prbs_still_locked");
        expect_at(0, 1, 4, 0, "prbs_sticky_clear");
    endtask

    // 3-bit counters: both saturate at all-ones.
    task automatic proc_c();
        en2 = 1'b1;
        tick(22);
        for (int i = 0; i < 10; i++) begin
            pf2 = 1'b1;
            tick(1);
            pf2 = 1'b0;
            tick(1);
        end
        tick(3);
        expect_at(0, 2, 2, 7, "err_saturate");
        expect_at(0, 2, 3, 7, "chk_saturate");
        expect_at(0, 2, 1, 1, "sat_locked");
        expect_at(0, 2, 4, 1, "sat_sticky");
    endtask

    initial begin
        tick(1);                                       // cycle 1
        expect_at(0, 0, 5, 0, "reset_quiet0");
        expect_at(0, 1, 5, 0, "reset_quiet1");
        expect_at(0, 2, 5, 0, "reset_quiet2");
        tick(1);
        rst_n = 1'b1;
        expect_at(2, 0, 0, 0, "idle_before_enable");
        tick(3);                                       // cycle 5
        fork
            proc_a();
            proc_b();
            proc_c();
        join
        tick(2);
        expect_at(0, 1, 1, 1, "pre_reset_locked");
        @(posedge clk);
        #2;
        expect_at(0, 0, 5, 0, "async_reset0");
        expect_at(0, 1, 5, 0, "async_reset1");
        expect_at(0, 2, 5, 0, "async_reset2");
        rst_n = 1'b0;
        tick(3);
        checks++;
        if (st0 !== 2'd0 || lk0 !== 1'b0 || ec0 !== 32'd0) begin
            errors++;
            $display("FAIL held_reset0 state %0d locked %0b err %0h", st0, lk0, ec0);
        end
        checks++;
        if (st1 !== 2'd0 || lk1 !== 1'b0 || cc1 !== 32'd0) begin
            errors++;
            $display("FAIL held_reset1 state %0d locked %0b chk %0h", st1, lk1, cc1);
        end
        checks++;
        if (ec2 !== 3'd0 || cc2 !== 3'd0 || sk2 !== 1'b0) begin
            errors++;
            $display("FAIL held_reset2 err %0h chk %0h sticky %0b", ec2, cc2, sk2);
        end
        foreach (sb[i]) begin
            errors++;
            $display("FAIL %s dut%0d never sampled at cycle %0d, expected %0h", sb[i].name,
                     sb[i].dut, sb[i].at, sb[i].exp);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        if (errors != 0) $display("TEST FAILED");
        else             $display("TEST PASSED");
        $finish;
    end

endmodule
